// File: rtl/cv32e40px_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40px_rf_write_arbiter
//
// Arbitrates register-file write requests from three producers
// (0 = ALU, 1 = LSU, 2 = FPU/X-if) onto two registered write ports (A, B).
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   req_valid_i  : [r] write request present
//   req_addr_i   : [r] destination register (bit 5 selects the FP bank)
//   req_data_i   : [r] write data
//   req_ready_o  : [r] combinational grant, handshake = valid & ready
//   waddr_a_o / wdata_a_o / we_a_o : registered write port A (W1)
//   waddr_b_o / wdata_b_o / we_b_o : registered write port B (W2)
//   busy_o       : registered, a valid request went ungranted last cycle
// ---------------------------------------------------------------------------
module cv32e40px_rf_write_arbiter #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [2:0]                           req_valid_i,
  input  logic [2:0][ADDR_WIDTH-1:0]           req_addr_i,
  input  logic [2:0][DATA_WIDTH-1:0]           req_data_i,
  output logic [2:0]                           req_ready_o,
  output logic [ADDR_WIDTH-1:0]                waddr_a_o,
  output logic [DATA_WIDTH-1:0]                wdata_a_o,
  output logic                                 we_a_o,
  output logic [ADDR_WIDTH-1:0]                waddr_b_o,
  output logic [DATA_WIDTH-1:0]                wdata_b_o,
  output logic                                 we_b_o,
  output logic                                 busy_o
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  // Round-robin pointer: 0 -> requester 1 has the turn, 1 -> requester 2.
  logic                  r_rr_is2;
  logic [2:0]            r_cnt1;
  logic [2:0]            r_cnt2;
  logic                  r_we_a;
  logic                  r_we_b;
  logic [ADDR_WIDTH-1:0] r_waddr_a;
  logic [ADDR_WIDTH-1:0] r_waddr_b;
  logic [DATA_WIDTH-1:0] r_wdata_a;
  logic [DATA_WIDTH-1:0] r_wdata_b;
  logic                  r_busy;

  logic [2:0]            w_boost;
  logic [1:0]            w_first;
  logic [1:0]            w_second;
  logic [1:0]            w_ord [5];
  logic [4:0]            w_ord_en;
  logic [1:0]            w_idx;
  logic [2:0]            w_grant;
  logic                  w_use_a;
  logic                  w_use_b;
  logic [1:0]            w_sel_a;
  logic [1:0]            w_sel_b;

  assign w_boost  = {r_cnt2 == LIMIT, r_cnt1 == LIMIT, 1'b0};
  assign w_first  = r_rr_is2 ? 2'd2 : 2'd1;
  assign w_second = r_rr_is2 ? 2'd1 : 2'd2;

  // Priority walk: boosted requesters (round-robin order), then requester 0,
  // then non-boosted requesters (round-robin order). Each requester is
  // enabled in exactly one of the five slots.
  always_comb begin
    w_ord[0]    = w_first;
    w_ord[1]    = w_second;
    w_ord[2]    = 2'd0;
    w_ord[3]    = w_first;
    w_ord[4]    = w_second;
    w_ord_en[0] = w_boost[w_first];
    w_ord_en[1] = w_boost[w_second];
    w_ord_en[2] = 1'b1;
    w_ord_en[3] = !w_boost[w_first];
    w_ord_en[4] = !w_boost[w_second];
  end

  // Address-0 writes are acknowledged without consuming a port. Port B only
  // fills after port A, so comparing against A's address alone prevents a
  // same-address dual write.
  always_comb begin
    w_grant = '0;
    w_use_a = 1'b0;
    w_use_b = 1'b0;
    w_sel_a = 2'd0;
    w_sel_b = 2'd0;
    w_idx   = 2'd0;
    for (int i = 0; i < 5; i++) begin
      w_idx = w_ord[i];
      if (rst_n && w_ord_en[i] && req_valid_i[w_idx]) begin
        if (req_addr_i[w_idx] == '0) begin
          w_grant[w_idx] = 1'b1;
        end else if (!w_use_a) begin
          w_use_a        = 1'b1;
          w_sel_a        = w_idx;
          w_grant[w_idx] = 1'b1;
        end else if (!w_use_b && (req_addr_i[w_idx] != req_addr_i[w_sel_a])) begin
          w_use_b        = 1'b1;
          w_sel_b        = w_idx;
          w_grant[w_idx] = 1'b1;
        end
      end
    end
  end

  assign req_ready_o = w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_is2  <= 1'b0;
      r_cnt1    <= '0;
      r_cnt2    <= '0;
      r_we_a    <= 1'b0;
      r_we_b    <= 1'b0;
      r_waddr_a <= '0;
      r_waddr_b <= '0;
      r_wdata_a <= '0;
      r_wdata_b <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_we_a <= w_use_a;
      r_we_b <= w_use_b;
      if (w_use_a) begin
        r_waddr_a <= req_addr_i[w_sel_a];
        r_wdata_a <= req_data_i[w_sel_a];
      end
      if (w_use_b) begin
        r_waddr_b <= req_addr_i[w_sel_b];
        r_wdata_b <= req_data_i[w_sel_b];
      end
      r_busy <= |(req_valid_i & ~w_grant);
      if (w_grant[w_first]) begin
        r_rr_is2 <= ~r_rr_is2;
      end
      // Saturating wait counters; cleared whenever the requester is idle or served.
      if (!req_valid_i[1] || w_grant[1]) begin
        r_cnt1 <= '0;
      end else if (r_cnt1 != 3'd7) begin
        r_cnt1 <= r_cnt1 + 3'd1;
      end
      if (!req_valid_i[2] || w_grant[2]) begin
        r_cnt2 <= '0;
      end else if (r_cnt2 != 3'd7) begin
        r_cnt2 <= r_cnt2 + 3'd1;
      end
    end
  end

  assign we_a_o    = r_we_a;
  assign we_b_o    = r_we_b;
  assign waddr_a_o = r_waddr_a;
  assign waddr_b_o = r_waddr_b;
  assign wdata_a_o = r_wdata_a;
  assign wdata_b_o = r_wdata_b;
  assign busy_o    = r_busy;

endmodule

// File: doc/cv32e40px_rf_write_arbiter.md
CV32E40PX_RF_WRITE_ARBITER -- requirements
Module: cv32e40px_rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, register address width (bit 5 selects the FP bank).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, write data width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, range 1..7, wait cycles before a requester is boosted.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-006 For each requester r in {0,1,2} (0=ALU, 1=LSU, 2=FPU/X-if), the block SHALL have port req_valid_i[r], input, 1, write request present.
REQ-007 The block SHALL have ports req_addr_i[r] (input, ADDR_WIDTH) and req_data_i[r] (input, DATA_WIDTH), the request payload.
REQ-008 The block SHALL have port req_ready_o[r], output, 1, combinational grant; handshake = valid & ready.
REQ-009 The block SHALL have ports waddr_a_o (ADDR_WIDTH), wdata_a_o (DATA_WIDTH) and we_a_o (1), all outputs, register-file write port W1, registered.
REQ-010 The block SHALL have ports waddr_b_o (ADDR_WIDTH), wdata_b_o (DATA_WIDTH) and we_b_o (1), all outputs, register-file write port W2, registered.
REQ-011 The block SHALL have port busy_o, output, 1, registered; high when any req_valid_i was high and not granted in the previous cycle.

Function
REQ-012 A requester SHALL hold valid, addr and data stable from valid assertion until handshake; the arbiter's behaviour is undefined otherwise.
REQ-013 req_ready_o SHALL depend only on the current-cycle valid/addr inputs and internal state, never on write-port outputs.
REQ-014 Each cycle, priority order SHALL be: boosted requesters in round-robin order, then req 0, then non-boosted requesters 1/2 in round-robin order.
REQ-015 Walking that order, at most two requests with nonzero address SHALL be granted; the first granted SHALL map to port A and the second to port B.
REQ-016 A request whose address equals an address already granted in the same cycle SHALL NOT be granted that cycle (no same-address dual write).
REQ-017 A request with address 0 SHALL be granted immediately, SHALL consume no port, and SHALL produce no write enable.
REQ-018 On the edge following a handshake, we_x_o SHALL be 1 with waddr_x_o/wdata_x_o equal to the granted payload (1-cycle latency); otherwise we_x_o SHALL be 0 and addr/data SHALL hold their previous values.
REQ-019 Round-robin pointer rr_q in {1,2}: after any cycle in which requester rr_q is granted, rr_q SHALL flip to the other requester; otherwise it SHALL hold.
REQ-020 Requesters 1 and 2 SHALL each have a 3-bit saturating wait counter: increment when valid & !ready, clear on handshake or when !valid.
REQ-021 A requester SHALL be boosted while its counter equals STARVE_LIMIT; requester 0 is never boosted and has no counter.
REQ-022 Grants SHALL be issued even when no request is pending on the other ports; there SHALL be no idle cycles between back-to-back grants to the same requester.

Reset
REQ-023 While rst_n is low, we_a_o, we_b_o and busy_o SHALL be 0, waddr/wdata outputs SHALL be 0, rr_q SHALL be 1, and wait counters SHALL be 0.
REQ-024 While rst_n is low, req_ready_o SHALL be 0 for all requesters.
REQ-025 A reset asserted mid-request SHALL drop the request without a write; a write registered before reset assertion SHALL be cleared asynchronously.

Verification
REQ-026 Scenario (three-way contention): all three requesters valid, addrs 3/5/7, rr_q=1 -> req0 and req1 granted; next cycle we_a_o=1 with waddr 3 and we_b_o=1 with waddr 5; req2 granted the following cycle on port A.
REQ-027 Scenario (address conflict): req0 addr 9 and req1 addr 9 valid -> only req0 granted; req1 granted the next cycle, producing two sequential writes to 9, req1's data last.
REQ-028 Scenario (x0 write): req1 addr 0 with req0 addr 4 and req2 addr 6 -> all three ready in one cycle; we_a_o=1 (waddr 4), we_b_o=1 (waddr 6), no write to 0.
REQ-029 Scenario (starvation): req0 and req1 continuously valid with distinct addrs, req2 valid; force req2 to lose (addr equal to req0's) for 4 cycles -> on cycle 5 req2 is boosted and granted on port A.
REQ-030 Scenario (reset mid-operation): rst_n pulled low while we_a_o=1 and req2 is waiting -> outputs and counters zero asynchronously; after release, req2 is re-arbitrated with rr_q=1.
